// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Single-outstanding APB initiator turning cmd/rsp requests into
//            SETUP/ACCESS transfers; APB_MASTER_TIMEOUT_EN adds ACCESS timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
    $error("apb_master_bridge: TIMEOUT_CYCLES must be within 2..255");
  end

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_error_q, rsp_error_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]          wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        // cmd_ready_q is low for the first cycle after reset release
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_error_d = 1'b0;
          state_d     = IDLE;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : Scoreboard bench for apb_master_bridge with a wait-state APB slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

  localparam int TO      = 16;
  localparam int LIMIT   = 200;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int EXP_RSP = 6;
`else
  localparam int EXP_RSP = 5;
`endif

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       psel, penable, pwrite;
  logic [4:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic [7:0] prdata;

  apb_master_bridge #(.ADDR_W(5), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rsp    = 0;
  logic [8:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge pclk) cyc <= cyc + 1;

  // Slave: stalls for wait_cfg ACCESS cycles (forever when stall is set)
  logic [7:0]  mem [32];
  logic [31:0] mem_vld = '0;
  int          acc_cnt;
  bit          stall = 1'b0;
  int          wait_cfg = 0;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn)                        acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                                 acc_cnt <= 0;
  end

  always @(posedge pclk) begin
    if (presetn && psel && penable && pready && pwrite) begin
      mem[paddr]     <= pwdata;
      mem_vld[paddr] <= 1'b1;
    end
  end

  assign pready = !stall && (acc_cnt >= wait_cfg);
  assign prdata = mem_vld[paddr] ? mem[paddr] : ((paddr == 5'h1F) ? 8'hA7 : {3'b000, paddr});

  // Response scoreboard and bus-protocol monitor
  logic [8:0] exp_rsp;
  logic       prev_rv = 1'b0;
  logic [4:0] cap_addr;
  logic [7:0] cap_wdata;
  logic       cap_write;

  always @(negedge pclk) begin
    if (presetn) begin
      if (rsp_valid) begin
        check_eq("rsp_pulse_len", prev_rv, 1'b0);
        check_eq("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          exp_rsp = sb_q.pop_front();
          check_eq("rsp_error", rsp_error, exp_rsp[8]);
          check_eq("rsp_rdata", rsp_rdata, exp_rsp[7:0]);
        end
        n_rsp++;
      end
      if (psel && !penable) begin
        cap_addr  = paddr;
        cap_wdata = pwdata;
        cap_write = pwrite;
        check_eq("setup_cmd_ready", cmd_ready, 1'b0);
        if (!pwrite) check_eq("read_pwdata_zero", pwdata, 8'h00);
      end
      if (penable) begin
        check_eq("access_psel", psel, 1'b1);
        check_eq("access_paddr_stable", paddr, cap_addr);
        check_eq("access_pwdata_stable", pwdata, cap_wdata);
        check_eq("access_pwrite_stable", pwrite, cap_write);
        check_eq("access_cmd_ready", cmd_ready, 1'b0);
      end
    end
    prev_rv = rsp_valid;
  end

  task automatic send(input logic wr, input logic [4:0] a, input logic [7:0] d,
                      input bit push, input logic err, input logic [7:0] rd,
                      output int acc_cyc);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < LIMIT) begin
      @(negedge pclk);
      n++;
    end
    check_eq("accept_wait", n < LIMIT, 1'b1);
    if (push) sb_q.push_back({err, rd});
    @(negedge pclk);
    acc_cyc = cyc;
  endtask

  task automatic wait_rsp(output int rc);
    int n = 0;
    while (!rsp_valid && n < LIMIT) begin
      @(negedge pclk);
      n++;
    end
    check_eq("rsp_wait", n < LIMIT, 1'b1);
    rc = cyc;
    @(negedge pclk);
  endtask

  int a0, a1, a2, rc, snap;

  initial begin
    // Reset held across several clock edges, released mid-cycle
    repeat (3) @(negedge pclk);
    check_eq("rst_bus", {psel, penable, pwrite, paddr, pwdata}, 16'h0000);
    check_eq("rst_rsp", {rsp_valid, rsp_error, rsp_rdata}, 10'h000);
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    #2 presetn = 1'b1;
    @(negedge pclk);
    check_eq("cmd_ready_after_rst", cmd_ready, 1'b1);

    // Zero-wait write
    send(1'b1, 5'h0A, 8'h5C, 1'b1, 1'b0, 8'h00, a0);
    check_eq("wr_setup", {psel, penable, cmd_ready}, 3'b100);
    cmd_valid = 1'b0;
    @(negedge pclk);
    check_eq("wr_access", {psel, penable, pwrite}, 3'b111);
    check_eq("wr_paddr", paddr, 5'h0A);
    check_eq("wr_pwdata", pwdata, 8'h5C);
    @(negedge pclk);
    check_eq("wr_rsp_valid", rsp_valid, 1'b1);
    check_eq("wr_latency", cyc - a0, 2);
    check_eq("wr_bus_idle", {psel, penable, cmd_ready}, 3'b001);
    check_eq("wr_slave_mem", mem[10], 8'h5C);

    // Read with three wait states
    wait_cfg = 3;
    send(1'b0, 5'h1F, 8'hFF, 1'b1, 1'b0, 8'hA7, a0);
    cmd_valid = 1'b0;
    wait_rsp(rc);
    check_eq("rd_wait_latency", rc - a0, 5);

    // Back-to-back with cmd_valid held high
    wait_cfg = 0;
    send(1'b1, 5'h03, 8'h11, 1'b1, 1'b0, 8'h00, a0);
    send(1'b1, 5'h11, 8'h3C, 1'b1, 1'b0, 8'h00, a1);
    send(1'b0, 5'h03, 8'h00, 1'b1, 1'b0, 8'h11, a2);
    cmd_valid = 1'b0;
    check_eq("b2b_gap1", a1 - a0, 3);
    check_eq("b2b_gap2", a2 - a1, 3);
    wait_rsp(rc);
    check_eq("b2b_rd_latency", rc - a2, 2);
    check_eq("b2b_slave_mem", mem[17], 8'h3C);

    // Slave never ready
    stall = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
    send(1'b0, 5'h07, 8'h00, 1'b1, 1'b1, 8'h00, a0);
    cmd_valid = 1'b0;
    wait_rsp(rc);
    check_eq("timeout_latency", rc - a0, TO + 1);
    send(1'b0, 5'h08, 8'h00, 1'b0, 1'b0, 8'h00, a0);
    cmd_valid = 1'b0;
    @(negedge pclk);
`else
    snap = n_rsp;
    send(1'b0, 5'h07, 8'h00, 1'b0, 1'b0, 8'h00, a0);
    cmd_valid = 1'b0;
    repeat (40) @(negedge pclk);
    check_eq("stall_still_access", {psel, penable}, 2'b11);
    check_eq("stall_no_rsp", n_rsp, snap);
`endif

    // Reset in the middle of ACCESS
    check_eq("pre_rst_penable", penable, 1'b1);
    snap = n_rsp;
    #2 presetn = 1'b0;
    #1;
    check_eq("async_rst_bus", {psel, penable}, 2'b00);
    check_eq("async_rst_rsp", rsp_valid, 1'b0);
    check_eq("async_rst_ready", cmd_ready, 1'b0);
    sb_q.delete();
    stall = 1'b0;
    repeat (2) @(negedge pclk);
    #3 presetn = 1'b1;
    repeat (6) @(negedge pclk);
    check_eq("post_rst_no_rsp", n_rsp, snap);
    check_eq("post_rst_ready", cmd_ready, 1'b1);
    check_eq("post_rst_bus", {psel, penable}, 2'b00);

    check_eq("rsp_count", n_rsp, EXP_RSP);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
